e_multi_sched: RTL and testbench

- Sequential dispatcher for a bank of N_ENTRIES multi-select entries. Each entry carries a valid bit and a RADIX_N-bit select vector.
- On start, snapshots all entries that hit (valid and non-zero select). Issues them one per handshake in ascending index order over a valid/ready grant port.
- Steers successive grants alternately to lane 0 / lane 1 using a registered region bit. This is the same alternate-hit region toggle the combinational multi-cell chain uses, carried across cycles and batches.

---
 rtl/e_multi_sched.sv | 104 ++++++++++
 tb/tb_e_multi_sched.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/e_multi_sched.sv
// Batch dispatcher: snapshots hitting entries, grants them in index order over valid/ready.
// Optional E_MULTI_SCHED_REGION_CLR_EN clears the lane region bit at each batch capture.
module e_multi_sched #(
  parameter int N_ENTRIES = 8,
  parameter int RADIX_N   = 4
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic                         start_i,
  input  logic [N_ENTRIES-1:0]         vld_i,
  input  logic [N_ENTRIES*RADIX_N-1:0] sel_i,
  output logic                         busy_o,
  output logic                         gnt_vld_o,
  input  logic                         gnt_rdy_i,
  output logic [$clog2(N_ENTRIES)-1:0] gnt_idx_o,
  output logic [RADIX_N-1:0]           gnt_sel_o,
  output logic                         gnt_lane_o,
  output logic                         done_o,
  output logic                         region_o
);

  localparam int IDX_W = $clog2(N_ENTRIES);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t                       state_q, state_d;
  logic [N_ENTRIES-1:0]         pending_q;
  logic [N_ENTRIES*RADIX_N-1:0] sel_q;
  logic                         region_q;

  logic [N_ENTRIES-1:0] hit;
  logic [N_ENTRIES-1:0] pend_clr;
  logic [IDX_W-1:0]     low_idx;
  logic                 scan;
  logic                 capture;
  logic                 accept;

  always_comb begin
    hit = '0;
    for (int k = 0; k < N_ENTRIES; k++)
      hit[k] = vld_i[k] & (|sel_i[k*RADIX_N +: RADIX_N]);
  end

  // Descending scan so the lowest pending index wins.
  always_comb begin
    low_idx = '0;
    for (int k = N_ENTRIES - 1; k >= 0; k--)
      if (pending_q[k]) low_idx = IDX_W'(k);
  end

  always_comb begin
    pend_clr = pending_q;
    pend_clr[low_idx] = 1'b0;
  end

  assign scan    = (state_q == SCAN);
  assign capture = (state_q == IDLE) & start_i;
  assign accept  = scan & gnt_rdy_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = (|hit) ? SCAN : DONE;
      SCAN:    if (gnt_rdy_i && pend_clr == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      pending_q <= '0;
      sel_q     <= '0;
      region_q  <= 1'b0;
    end else if (capture) begin
      pending_q <= hit;
      sel_q     <= sel_i;
`ifdef E_MULTI_SCHED_REGION_CLR_EN
      region_q  <= 1'b0;
`endif
    end else if (accept) begin
      pending_q <= pend_clr;
      region_q  <= ~region_q;
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign gnt_vld_o  = scan;
  assign gnt_idx_o  = scan ? low_idx : '0;
  assign gnt_sel_o  = scan ? sel_q[int'(low_idx)*RADIX_N +: RADIX_N] : '0;
  assign gnt_lane_o = scan & region_q;
  assign done_o     = (state_q == DONE);
  assign region_o   = region_q;

endmodule

// File: tb/tb_e_multi_sched.sv
// Directed bench for e_multi_sched (N_ENTRIES=8, RADIX_N=4).
// Lane expectations follow E_MULTI_SCHED_REGION_CLR_EN when defined.
module tb_e_multi_sched;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        start_i = 1'b0;
  logic [7:0]  vld_i = '0;
  logic [31:0] sel_i = '0;
  logic        busy_o, gnt_vld_o, gnt_rdy_i, gnt_lane_o, done_o, region_o;
  logic [2:0]  gnt_idx_o;
  logic [3:0]  gnt_sel_o;

  int checks = 0;
  int failures = 0;

  e_multi_sched #(.N_ENTRIES(8), .RADIX_N(4)) dut (
    .clk(clk), .arst(arst), .start_i(start_i), .vld_i(vld_i),
    .sel_i(sel_i), .busy_o(busy_o), .gnt_vld_o(gnt_vld_o),
    .gnt_rdy_i(gnt_rdy_i), .gnt_idx_o(gnt_idx_o),
    .gnt_sel_o(gnt_sel_o), .gnt_lane_o(gnt_lane_o),
    .done_o(done_o), .region_o(region_o)
  );

  always #5 clk = ~clk;

  // Stimulus only: called at a negedge, returns at the negedge after capture.
  task automatic do_start(input logic [7:0] v, input logic [31:0] s);
    start_i = 1'b1;
    vld_i = v;
    sel_i = s;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] all;
    gnt_rdy_i = 1'b0;
    repeat (2) @(negedge clk);
    arst = 1'b0;
    all = {busy_o, gnt_vld_o, gnt_idx_o, gnt_sel_o, gnt_lane_o, done_o, region_o};
    checks++;
    if (all !== 13'd0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=0", all);
    end
    @(negedge clk);
    do_start(8'h03, 32'h0000_0055);
    checks++;
    if (gnt_vld_o !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_vld got=%b exp=1", gnt_vld_o);
    end
    #2 arst = 1'b1;
    #1;
    all = {busy_o, gnt_vld_o, gnt_idx_o, gnt_sel_o, gnt_lane_o, done_o, region_o};
    checks++;
    if (all !== 13'd0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=0", all);
    end
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy_o, done_o, region_o, gnt_vld_o} !== 4'b0) begin
      failures++;
      $display("FAIL post_reset busy/done/region/vld got=%b exp=0000",
               {busy_o, done_o, region_o, gnt_vld_o});
    end
  endtask

  task automatic test_basic();
    logic [2:0] exp_idx [4];
    logic       exp_lane [4];
    exp_idx  = '{3'd1, 3'd2, 3'd5, 3'd7};
    exp_lane = '{1'b0, 1'b1, 1'b0, 1'b1};
    gnt_rdy_i = 1'b1;
    do_start(8'b1010_0110, 32'h1111_1111);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({gnt_vld_o, gnt_idx_o, gnt_sel_o, gnt_lane_o, done_o} !==
          {1'b1, exp_idx[i], 4'h1, exp_lane[i], 1'b0}) begin
        failures++;
        $display("FAIL basic_grant%0d got vld=%b idx=%0d sel=%h lane=%b done=%b exp idx=%0d lane=%b",
                 i, gnt_vld_o, gnt_idx_o, gnt_sel_o, gnt_lane_o, done_o,
                 exp_idx[i], exp_lane[i]);
      end
      @(negedge clk);
    end
    checks++;
    if ({done_o, gnt_vld_o, region_o} !== 3'b100) begin
      failures++;
      $display("FAIL basic_done done/vld/region got=%b exp=100",
               {done_o, gnt_vld_o, region_o});
    end
    @(negedge clk);
    checks++;
    if ({done_o, busy_o} !== 2'b00) begin
      failures++;
      $display("FAIL basic_idle done/busy got=%b exp=00", {done_o, busy_o});
    end
  endtask

  task automatic test_zero_sel();
    gnt_rdy_i = 1'b1;
    do_start(8'hFF, 32'h0200_8000);
    checks++;
    if ({gnt_vld_o, gnt_idx_o, gnt_sel_o, gnt_lane_o} !== {1'b1, 3'd3, 4'h8, 1'b0}) begin
      failures++;
      $display("FAIL zsel_g0 got idx=%0d sel=%h lane=%b exp idx=3 sel=8 lane=0",
               gnt_idx_o, gnt_sel_o, gnt_lane_o);
    end
    @(negedge clk);
    checks++;
    if ({gnt_vld_o, gnt_idx_o, gnt_sel_o, gnt_lane_o} !== {1'b1, 3'd6, 4'h2, 1'b1}) begin
      failures++;
      $display("FAIL zsel_g1 got idx=%0d sel=%h lane=%b exp idx=6 sel=2 lane=1",
               gnt_idx_o, gnt_sel_o, gnt_lane_o);
    end
    @(negedge clk);
    checks++;
    if ({done_o, gnt_vld_o} !== 2'b10) begin
      failures++;
      $display("FAIL zsel_done done/vld got=%b exp=10", {done_o, gnt_vld_o});
    end
    @(negedge clk);
  endtask

  task automatic test_back_pressure();
    gnt_rdy_i = 1'b0;
    do_start(8'b0001_0001, 32'h0003_000C);
    vld_i = 8'hFF;
    sel_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({gnt_vld_o, gnt_idx_o, gnt_sel_o, gnt_lane_o} !== {1'b1, 3'd0, 4'hC, 1'b0}) begin
        failures++;
        $display("FAIL bp_stall%0d got vld=%b idx=%0d sel=%h lane=%b exp idx=0 sel=c lane=0",
                 i, gnt_vld_o, gnt_idx_o, gnt_sel_o, gnt_lane_o);
      end
      if (i == 2) gnt_rdy_i = 1'b1;
      @(negedge clk);
    end
    checks++;
    if ({gnt_vld_o, gnt_idx_o, gnt_sel_o, gnt_lane_o} !== {1'b1, 3'd4, 4'h3, 1'b1}) begin
      failures++;
      $display("FAIL bp_second got idx=%0d sel=%h lane=%b exp idx=4 sel=3 lane=1",
               gnt_idx_o, gnt_sel_o, gnt_lane_o);
    end
    @(negedge clk);
    checks++;
    if (done_o !== 1'b1) begin
      failures++;
      $display("FAIL bp_done got=%b exp=1", done_o);
    end
    @(negedge clk);
  endtask

  task automatic test_empty();
    gnt_rdy_i = 1'b1;
    do_start(8'h00, 32'hFFFF_FFFF);
    checks++;
    if ({done_o, gnt_vld_o, busy_o} !== 3'b101) begin
      failures++;
      $display("FAIL empty_done done/vld/busy got=%b exp=101",
               {done_o, gnt_vld_o, busy_o});
    end
    @(negedge clk);
    checks++;
    if ({done_o, busy_o, region_o} !== 3'b000) begin
      failures++;
      $display("FAIL empty_idle done/busy/region got=%b exp=000",
               {done_o, busy_o, region_o});
    end
  endtask

  task automatic test_start_busy();
    gnt_rdy_i = 1'b0;
    do_start(8'b0100_1000, 32'hFFFF_FFFF);
    start_i = 1'b1;
    vld_i = 8'hFF;
    sel_i = 32'h1111_1111;
    @(negedge clk);
    start_i = 1'b0;
    checks++;
    if ({gnt_vld_o, gnt_idx_o, gnt_sel_o, gnt_lane_o} !== {1'b1, 3'd3, 4'hF, 1'b0}) begin
      failures++;
      $display("FAIL busy_g0 got idx=%0d sel=%h lane=%b exp idx=3 sel=f lane=0",
               gnt_idx_o, gnt_sel_o, gnt_lane_o);
    end
    gnt_rdy_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({gnt_vld_o, gnt_idx_o, gnt_sel_o, gnt_lane_o} !== {1'b1, 3'd6, 4'hF, 1'b1}) begin
      failures++;
      $display("FAIL busy_g1 got idx=%0d sel=%h lane=%b exp idx=6 sel=f lane=1",
               gnt_idx_o, gnt_sel_o, gnt_lane_o);
    end
    @(negedge clk);
    checks++;
    if ({done_o, gnt_vld_o} !== 2'b10) begin
      failures++;
      $display("FAIL busy_done done/vld got=%b exp=10", {done_o, gnt_vld_o});
    end
    @(negedge clk);
  endtask

  task automatic test_region_carry();
    logic exp_a [3];
    logic exp_b [2];
    logic [1:0] exp_idx_b [2];
    logic exp_reg;
    exp_a = '{1'b0, 1'b1, 1'b0};
`ifdef E_MULTI_SCHED_REGION_CLR_EN
    exp_b = '{1'b0, 1'b1};
    exp_reg = 1'b0;
`else
    exp_b = '{1'b1, 1'b0};
    exp_reg = 1'b1;
`endif
    exp_idx_b = '{2'd0, 2'd3};
    gnt_rdy_i = 1'b1;
    do_start(8'b0000_0111, 32'h1111_1111);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({gnt_vld_o, gnt_idx_o, gnt_lane_o} !== {1'b1, 3'(i), exp_a[i]}) begin
        failures++;
        $display("FAIL carry_a%0d got vld=%b idx=%0d lane=%b exp idx=%0d lane=%b",
                 i, gnt_vld_o, gnt_idx_o, gnt_lane_o, i, exp_a[i]);
      end
      @(negedge clk);
    end
    @(negedge clk);
    do_start(8'b1000_0001, 32'h1111_1111);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({gnt_vld_o, gnt_idx_o, gnt_lane_o} !==
          {1'b1, (exp_idx_b[i] == 2'd3) ? 3'd7 : 3'd0, exp_b[i]}) begin
        failures++;
        $display("FAIL carry_b%0d got vld=%b idx=%0d lane=%b exp lane=%b",
                 i, gnt_vld_o, gnt_idx_o, gnt_lane_o, exp_b[i]);
      end
      @(negedge clk);
    end
    checks++;
    if ({done_o, region_o} !== {1'b1, exp_reg}) begin
      failures++;
      $display("FAIL carry_done done/region got=%b exp=%b",
               {done_o, region_o}, {1'b1, exp_reg});
    end
    @(negedge clk);
  endtask

  initial begin
    gnt_rdy_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_zero_sel();
    test_back_pressure();
    test_empty();
    test_start_busy();
    test_region_carry();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
